aes_core_rr_arbiter: RTL

//  Shares one iterative AES core (aes_fsm_gen plus its datapath) between N_REQ requesters.

---
 rtl/aes_core_rr_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_core_rr_arbiter.sv
// aes_core_rr_arbiter
//   Round-robin arbiter sharing one iterative AES core between N_REQ requesters.
//   A winner is picked from the pending requests starting at rr_ptr; its mode and
//   direction are latched, the core is started, and when the core reports done a
//   one-cycle response goes back to the winner. An illegal key size (2'b11) skips
//   the core entirely and returns an error response.
//
// Optional feature: define AES_ARB_WDOG_EN to enable a RUN-state watchdog that
//   flushes the core and returns an error response after WDOG_CYCLES cycles.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   req            per-requester request level, held until own resp_valid
//   req_mode       per-requester key size, slice i = [2i+1:2i] (11 = illegal)
//   req_enc_dec    per-requester direction (0 encrypt, 1 decrypt)
//   gnt            one-hot grant, held from grant cycle through the response cycle
//   resp_valid     one-cycle completion pulse to the granted requester
//   resp_err       qualifies resp_valid (illegal mode or watchdog timeout)
//   busy           high whenever the arbiter is not idle
//   cur_id         index of the granted requester (0 when idle)
//   core_start     one-cycle start pulse to the AES core
//   core_mode      latched key size for the core
//   core_enc_dec   latched direction for the core
//   core_done      completion pulse from the AES core
//   core_flush     one-cycle core reset request on watchdog timeout
module aes_core_rr_arbiter #(
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned WDOG_CYCLES = 256,
  localparam int unsigned IDW         = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_mode,
  input  logic [N_REQ-1:0]     req_enc_dec,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [N_REQ-1:0]     resp_err,
  output logic                 busy,
  output logic [IDW-1:0]       cur_id,
  output logic                 core_start,
  output logic [1:0]           core_mode,
  output logic                 core_enc_dec,
  input  logic                 core_done,
  output logic                 core_flush
);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic             err_q;
  logic [1:0]       mode_q;
  logic             dir_q;
  logic [N_REQ-1:0] gnt_q;
  logic             core_start_q;
  logic             wdog_hit;

  // Round-robin pick: first pending request scanning rr_ptr, rr_ptr+1, ... mod N_REQ
  logic             pick_found;
  logic [IDW-1:0]   pick_id;
  logic [N_REQ-1:0] pick_gnt;
  logic [1:0]       pick_mode;
  logic             pick_illegal;

  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    pick_gnt   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % N_REQ;
      if (!pick_found && req[IDW'(idx)]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
    if (pick_found) pick_gnt[pick_id] = 1'b1;
  end

  assign pick_mode    = req_mode[{pick_id, 1'b0} +: 2];
  assign pick_illegal = (pick_mode == 2'b11);

`ifdef AES_ARB_WDOG_EN
  logic [15:0] wdog_cnt_q;
  logic        core_flush_q;

  // A done arriving in the timeout cycle takes precedence over the timeout.
  assign wdog_hit = (state_q == RUN) && !core_done &&
                    (wdog_cnt_q == 16'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q   <= '0;
      core_flush_q <= 1'b0;
    end else begin
      wdog_cnt_q   <= (state_q == RUN) ? wdog_cnt_q + 16'd1 : '0;
      core_flush_q <= wdog_hit;
    end
  end

  assign core_flush = core_flush_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
  assign core_flush  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = pick_illegal ? RESP : START;
      START:   state_d = RUN;
      RUN:     if (core_done || wdog_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, latched request attributes and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      mode_q       <= '0;
      dir_q        <= 1'b0;
      gnt_q        <= '0;
      core_start_q <= 1'b0;
    end else begin
      // Registered so the pulse lands one cycle after the grant becomes visible
      core_start_q <= (state_q == START);
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            id_q   <= pick_id;
            mode_q <= pick_mode;
            dir_q  <= req_enc_dec[pick_id];
            gnt_q  <= pick_gnt;
            err_q  <= pick_illegal;
          end
        end
        RUN: begin
          if (wdog_hit) err_q <= 1'b1;
        end
        RESP: begin
          gnt_q    <= '0;
          rr_ptr_q <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign resp_valid   = (state_q == RESP) ? gnt_q : '0;
  assign resp_err     = (state_q == RESP && err_q) ? gnt_q : '0;
  assign busy         = (state_q != IDLE);
  assign cur_id       = (state_q == IDLE) ? '0 : id_q;
  assign core_start   = core_start_q;
  assign core_mode    = mode_q;
  assign core_enc_dec = dir_q;

endmodule
